multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore FSM that sequences a shared-memory, single-ALU multicycle datapath for the team's MIPS subset: SUBU, NOR, SLTU, JR, BLTZ, J, ADDI, LW, SW.
- Drives PC/IR/register/memory enables, mux selects and the 2-bit ALU op.
- Memory accesses stall on a ready handshake; a watchdog traps a memory that never responds.

Parameters:
TIMEOUT, 255, consecutive not-ready cycles in any wait state before FAULT; 0 disables the watchdog.
CNT_W, 8, width of the wait counter; must hold TIMEOUT.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high; forces S_RST.
instruction  in  32  IR contents; op=[31:26], funct=[5:0]; valid from DECODE on.
rs_neg  in  1  sign bit of latched register A; used by BLTZ.
mem_ready  in  1  memory completes the current read/write this cycle.
pc_write  out  1  PC load enable.
ir_write  out  1  IR load enable.
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
reg_write  out  1  register file write enable.
reg_dest  out  1  write register select: 1=rd, 0=rt.
mem_to_reg  out  1  writeback select: 1=MDR, 0=ALUOut.
alu_src_a  out  1  ALU A select: 0=PC, 1=regA.
alu_src_b  out  2  ALU B select: 00=regB, 01=4, 10=sext(imm), 11=sext(imm)<<2.
alu_control  out  2  ALU op: 00=add, 01=sub, 10=nor, 11=sltu.
pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10={PC[31:28],instr[25:0],2'b00}, 11=regA.
instr_retired  out  1  one-cycle pulse in the final cycle of each instruction.
illegal_op  out  1  sticky; set on an undefined opcode.
fault  out  1  high while in FAULT.
state  out  4  current state encoding, for debug.

Behaviour:
- Outputs are decoded from state. The only exceptions are the pc_write/ir_write qualification by mem_ready and the BLTZ pc_write qualification by rs_neg. Any output not listed for a state is 0.
- Reset: state=S_RST, wait_cnt=0, illegal_op=0, all outputs 0. S_RST drives all outputs 0 and moves to FETCH on the next edge.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_control=00, pc_source=00. ir_write=pc_write=mem_ready. If mem_ready, go to DECODE; otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=00 (branch target into ALUOut). Next state by instruction:
  - op=000000, funct 100011/100111/101011 -> EXEC_R.
  - op=000000, funct 001000 -> JR_S.
  - op=000000, any other funct -> FETCH as a NOP, with instr_retired=1.
  - op=001000 -> EXEC_I.
  - op=100011 or 101011 -> MEM_ADDR.
  - op=000001 -> BRANCH.
  - op=000010 -> JUMP.
  - Any other opcode -> FETCH, with illegal_op set and instr_retired=1.
- EXEC_R: alu_src_a=1, alu_src_b=00. alu_control: SUBU=01, NOR=10, SLTU=11. Next -> R_WB.
- R_WB: reg_write=1, reg_dest=1, mem_to_reg=0, instr_retired=1. Next -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_control=00. Next -> I_WB.
- I_WB: reg_write=1, reg_dest=0, mem_to_reg=0, instr_retired=1. Next -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_control=00. Next -> MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. If mem_ready, go to LW_WB; otherwise hold.
- LW_WB: reg_write=1, reg_dest=0, mem_to_reg=1, instr_retired=1. Next -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; held until mem_ready. On the mem_ready cycle: instr_retired=1, then FETCH.
- BRANCH: pc_source=01, pc_write=rs_neg, instr_retired=1. Next -> FETCH.
- JUMP: pc_source=10, pc_write=1, instr_retired=1. Next -> FETCH.
- JR_S: pc_source=11, pc_write=1, instr_retired=1. Next -> FETCH.
- Watchdog (wait states are FETCH, MEM_RD, MEM_WR):
  - wait_cnt clears on entry to any state.
  - Each cycle in a wait state with mem_ready=0 increments wait_cnt.
  - If wait_cnt==TIMEOUT-1 and mem_ready=0 (and TIMEOUT!=0), next state is FAULT.
  - mem_ready=1 on that same cycle wins: normal transition, no fault.
- FAULT: all outputs 0 except fault=1 and the sticky illegal_op. Only reset exits FAULT.
- Latencies with zero wait states, counted from FETCH to the next FETCH:
  - J, JR, BLTZ: 3 cycles.
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronously), with no partial writes afterward. Restart is S_RST then FETCH.

Test Plan:
- Reset, then ADDI 0x20080005 with mem_ready=1 always -> state sequence S_RST, FETCH, DECODE, EXEC_I, I_WB, FETCH. In I_WB: reg_write=1, reg_dest=0, alu_src_b was 10 in EXEC_I, instr_retired pulses once.
- SUBU 0x01095023, then NOR (funct 0x27), then SLTU (funct 0x2B) -> EXEC_R alu_control 01, 10, 11 respectively; R_WB has reg_dest=1.
- LW 0x8C080004 with mem_ready low for 3 cycles in MEM_RD -> mem_read/i_or_d=1 held 4 cycles, then LW_WB with mem_to_reg=1. SW 0xAC080004 -> mem_write held until ready, no reg_write.
- BLTZ 0x05000003: rs_neg=1 -> pc_write=1, pc_source=01 in BRANCH; rs_neg=0 -> pc_write=0. J 0x08000010 -> pc_source=10. JR 0x03E00008 -> pc_source=11.
- Opcode 0xE8000000 -> DECODE then FETCH, illegal_op=1 and stays 1. R-type funct 0x00 -> NOP with illegal_op unchanged.
- TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 not-ready cycles, fault=1. Repeat with mem_ready=1 on the 4th cycle -> no fault. Reset asserted mid MEM_WR -> mem_write=0 immediately, restart via S_RST.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle MIPS-subset core.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_control_if;
   logic [31:0] instruction;
   logic        rs_neg;
   logic        mem_ready;
   logic        pc_write;
   logic        ir_write;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        reg_dest;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_control;
   logic [1:0]  pc_source;
   logic        instr_retired;
   logic        illegal_op;
   logic        fault;
   logic [3:0]  state;

   modport master (
      input  instruction, rs_neg, mem_ready,
      output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
             reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_control,
             pc_source, instr_retired, illegal_op, fault, state
   );

   modport slave (
      output instruction, rs_neg, mem_ready,
      input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
             reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_control,
             pc_source, instr_retired, illegal_op, fault, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the shared-memory, single-ALU multicycle datapath.
// Memory waits stall on mem_ready; a watchdog traps a memory that never answers.
module multicycle_control #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master ctrl
);

   // Encoding is visible on the debug state port, so values are pinned.
   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_R_WB     = 4'd4,
      S_EXEC_I   = 4'd5,
      S_I_WB     = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_LW_WB    = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_JR_S     = 4'd13,
      S_FAULT    = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLTU = 6'b101011;
   localparam logic [5:0] FN_JR   = 6'b001000;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             illegal_q;
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             in_wait;
   logic             timeout_hit;
   logic             dec_nop;
   logic             dec_illegal;
   logic             unused_bits;

   assign op          = ctrl.instruction[31:26];
   assign funct       = ctrl.instruction[5:0];
   assign unused_bits = ^ctrl.instruction[25:6];

   assign in_wait     = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
   // mem_ready on the last allowed cycle wins over the watchdog.
   assign timeout_hit = (TIMEOUT != 0) && in_wait && !ctrl.mem_ready &&
                        (wait_cnt == CNT_W'(TIMEOUT - 1));

   // Instructions that retire straight out of DECODE.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path can infer a latch.
      dec_nop     = 1'b0;
      dec_illegal = 1'b0;
      case (op)
         OP_RTYPE: dec_nop = !(funct inside {FN_SUBU, FN_NOR, FN_SLTU, FN_JR});
         OP_ADDI, OP_LW, OP_SW, OP_REGIMM, OP_J: ;
         default:  dec_illegal = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state_q <= S_RST;
      else       state_q <= state_d;
   end

   // Watchdog counter and sticky illegal-opcode flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (state_d != state_q)
            wait_cnt <= '0;
         else if (in_wait && !ctrl.mem_ready)
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (state_q == S_DECODE && dec_illegal)
            illegal_q <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:    state_d = S_FETCH;
         S_FETCH:  if (ctrl.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_RTYPE: begin
                  if (funct == FN_JR) state_d = S_JR_S;
                  else if (dec_nop)   state_d = S_FETCH;
                  else                state_d = S_EXEC_R;
               end
               OP_ADDI:      state_d = S_EXEC_I;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_REGIMM:    state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_EXEC_R:   state_d = S_R_WB;
         S_R_WB:     state_d = S_FETCH;
         S_EXEC_I:   state_d = S_I_WB;
         S_I_WB:     state_d = S_FETCH;
         S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (ctrl.mem_ready) state_d = S_LW_WB;
         S_LW_WB:    state_d = S_FETCH;
         S_MEM_WR:   if (ctrl.mem_ready) state_d = S_FETCH;
         S_BRANCH, S_JUMP, S_JR_S: state_d = S_FETCH;
         S_FAULT:    state_d = S_FAULT;
         default:    state_d = S_FAULT;   // unused encoding is treated as corruption
      endcase
      if (timeout_hit) state_d = S_FAULT;
   end

   // Output decode; pc_write/ir_write/instr_retired take the documented input qualifiers.
   always_comb begin
      ctrl.pc_write      = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.i_or_d        = 1'b0;
      ctrl.mem_read      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.reg_dest      = 1'b0;
      ctrl.mem_to_reg    = 1'b0;
      ctrl.alu_src_a     = 1'b0;
      ctrl.alu_src_b     = 2'b00;
      ctrl.alu_control   = 2'b00;
      ctrl.pc_source     = 2'b00;
      ctrl.instr_retired = 1'b0;
      ctrl.fault         = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = ctrl.mem_ready;
            ctrl.pc_write  = ctrl.mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b     = 2'b11;
            ctrl.instr_retired = dec_nop | dec_illegal;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            case (funct)
               FN_SUBU: ctrl.alu_control = 2'b01;
               FN_NOR:  ctrl.alu_control = 2'b10;
               FN_SLTU: ctrl.alu_control = 2'b11;
               default: ctrl.alu_control = 2'b00;
            endcase
         end
         S_R_WB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.reg_dest      = 1'b1;
            ctrl.instr_retired = 1'b1;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         S_I_WB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.instr_retired = 1'b1;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_LW_WB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.mem_to_reg    = 1'b1;
            ctrl.instr_retired = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write     = 1'b1;
            ctrl.i_or_d        = 1'b1;
            ctrl.instr_retired = ctrl.mem_ready;
         end
         S_BRANCH: begin
            ctrl.pc_source     = 2'b01;
            ctrl.pc_write      = ctrl.rs_neg;
            ctrl.instr_retired = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_source     = 2'b10;
            ctrl.pc_write      = 1'b1;
            ctrl.instr_retired = 1'b1;
         end
         S_JR_S: begin
            ctrl.pc_source     = 2'b11;
            ctrl.pc_write      = 1'b1;
            ctrl.instr_retired = 1'b1;
         end
         S_FAULT: ctrl.fault = 1'b1;
         default: ;
      endcase
   end

   assign ctrl.illegal_op = illegal_q;
   assign ctrl.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle stimulus and expected
// control vectors are queued per scenario, then replayed and compared cycle by cycle.
module tb_multicycle_control;

   localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
      S_EXEC_R = 4'd3, S_R_WB = 4'd4, S_EXEC_I = 4'd5, S_I_WB = 4'd6,
      S_MEM_ADDR = 4'd7, S_MEM_RD = 4'd8, S_LW_WB = 4'd9, S_MEM_WR = 4'd10,
      S_BRANCH = 4'd11, S_JUMP = 4'd12, S_JR_S = 4'd13, S_FAULT = 4'd14;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, iord, mrd, mwr, rw, rd, m2r, asa;
      logic [1:0] asb, aluc, pcs;
      logic       ret, ill, flt;
   } ctl_t;

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic        rsn;
      ctl_t        exp;
   } item_t;

   logic clk;
   logic reset;
   multicycle_control_if bus ();

   multicycle_control #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   item_t sb[$];
   int    checks = 0;
   int    errors = 0;
   logic  exp_ill = 1'b0;

   function automatic ctl_t observe();
      ctl_t o;
      o.st = bus.state;       o.pcw = bus.pc_write;    o.irw = bus.ir_write;
      o.iord = bus.i_or_d;    o.mrd = bus.mem_read;    o.mwr = bus.mem_write;
      o.rw = bus.reg_write;   o.rd = bus.reg_dest;     o.m2r = bus.mem_to_reg;
      o.asa = bus.alu_src_a;  o.asb = bus.alu_src_b;   o.aluc = bus.alu_control;
      o.pcs = bus.pc_source;  o.ret = bus.instr_retired;
      o.ill = bus.illegal_op; o.flt = bus.fault;
      return o;
   endfunction

   // Expected control vector per state, straight from the state table.
   function automatic ctl_t base(input logic [3:0] st);
      ctl_t c = '0;
      c.st = st; c.ill = exp_ill;
      return c;
   endfunction
   function automatic ctl_t f_fetch(input logic rdy);
      ctl_t c = base(S_FETCH);
      c.mrd = 1'b1; c.asb = 2'b01; c.pcw = rdy; c.irw = rdy;
      return c;
   endfunction
   function automatic ctl_t f_decode(input logic ret);
      ctl_t c = base(S_DECODE);
      c.asb = 2'b11; c.ret = ret;
      return c;
   endfunction
   function automatic ctl_t f_exec_r(input logic [1:0] aluc);
      ctl_t c = base(S_EXEC_R);
      c.asa = 1'b1; c.asb = 2'b00; c.aluc = aluc;
      return c;
   endfunction
   function automatic ctl_t f_r_wb();
      ctl_t c = base(S_R_WB);
      c.rw = 1'b1; c.rd = 1'b1; c.ret = 1'b1;
      return c;
   endfunction
   function automatic ctl_t f_alu_imm(input logic [3:0] st);
      ctl_t c = base(st);
      c.asa = 1'b1; c.asb = 2'b10;
      return c;
   endfunction
   function automatic ctl_t f_i_wb();
      ctl_t c = base(S_I_WB);
      c.rw = 1'b1; c.ret = 1'b1;
      return c;
   endfunction
   function automatic ctl_t f_mem_rd();
      ctl_t c = base(S_MEM_RD);
      c.mrd = 1'b1; c.iord = 1'b1;
      return c;
   endfunction
   function automatic ctl_t f_lw_wb();
      ctl_t c = base(S_LW_WB);
      c.rw = 1'b1; c.m2r = 1'b1; c.ret = 1'b1;
      return c;
   endfunction
   function automatic ctl_t f_mem_wr(input logic rdy);
      ctl_t c = base(S_MEM_WR);
      c.mwr = 1'b1; c.iord = 1'b1; c.ret = rdy;
      return c;
   endfunction
   function automatic ctl_t f_pc(input logic [3:0] st, input logic [1:0] pcs, input logic pcw);
      ctl_t c = base(st);
      c.pcs = pcs; c.pcw = pcw; c.ret = 1'b1;
      return c;
   endfunction
   function automatic ctl_t f_fault();
      ctl_t c = base(S_FAULT);
      c.flt = 1'b1;
      return c;
   endfunction

   task automatic push(input logic [31:0] instr, input logic rdy, input logic rsn, input ctl_t e);
      item_t it;
      it.instr = instr; it.rdy = rdy; it.rsn = rsn; it.exp = e;
      sb.push_back(it);
   endtask

   // Drives one cycle's inputs at the falling edge and lets outputs settle.
   task automatic apply(input item_t it);
      @(negedge clk);
      bus.instruction = it.instr;
      bus.mem_ready   = it.rdy;
      bus.rs_neg      = it.rsn;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      exp_ill = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      ctl_t got;
      #3;
      got = observe();
      checks++;
      if (got !== base(S_RST)) begin
         errors++;
         $display("FAIL reset_held: got %h expected %h", got, base(S_RST));
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      got = observe();
      checks++;
      if (got !== base(S_RST)) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", got, base(S_RST));
      end
   endtask

   task automatic test_addi();
      item_t it; ctl_t got; int n = 0;
      logic [31:0] addi = 32'h2008_0005;
      do_reset();
      push(addi, 1'b1, 1'b0, f_fetch(1'b1));
      push(addi, 1'b1, 1'b0, f_decode(1'b0));
      push(addi, 1'b1, 1'b0, f_alu_imm(S_EXEC_I));
      push(addi, 1'b1, 1'b0, f_i_wb());
      push(addi, 1'b1, 1'b0, f_fetch(1'b1));
      while (sb.size() != 0) begin
         it = sb.pop_front();
         apply(it);
         got = observe();
         checks++;
         if (got !== it.exp) begin
            errors++;
            $display("FAIL addi cycle %0d: got %h expected %h", n, got, it.exp);
         end
         n++;
      end
   endtask

   task automatic test_back_to_back_rtype();
      item_t it; ctl_t got; int n = 0;
      logic [31:0] prog [3];
      logic [1:0]  aluc [3];
      prog[0] = 32'h0109_5023; aluc[0] = 2'b01;   // SUBU
      prog[1] = 32'h0109_5027; aluc[1] = 2'b10;   // NOR
      prog[2] = 32'h0109_502B; aluc[2] = 2'b11;   // SLTU
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push(prog[i], 1'b1, 1'b0, f_fetch(1'b1));
         push(prog[i], 1'b1, 1'b0, f_decode(1'b0));
         push(prog[i], 1'b1, 1'b0, f_exec_r(aluc[i]));
         push(prog[i], 1'b1, 1'b0, f_r_wb());
      end
      push(prog[0], 1'b1, 1'b0, f_fetch(1'b1));
      while (sb.size() != 0) begin
         it = sb.pop_front();
         apply(it);
         got = observe();
         checks++;
         if (got !== it.exp) begin
            errors++;
            $display("FAIL rtype cycle %0d: got %h expected %h", n, got, it.exp);
         end
         n++;
      end
   endtask

   task automatic test_load_store();
      item_t it; ctl_t got; int n = 0;
      logic [31:0] lw = 32'h8C08_0004;
      logic [31:0] sw = 32'hAC08_0004;
      do_reset();
      push(lw, 1'b0, 1'b0, f_fetch(1'b0));
      push(lw, 1'b0, 1'b0, f_fetch(1'b0));
      push(lw, 1'b1, 1'b0, f_fetch(1'b1));
      push(lw, 1'b1, 1'b0, f_decode(1'b0));
      push(lw, 1'b1, 1'b0, f_alu_imm(S_MEM_ADDR));
      for (int i = 0; i < 3; i++) push(lw, 1'b0, 1'b0, f_mem_rd());
      push(lw, 1'b1, 1'b0, f_mem_rd());
      push(lw, 1'b1, 1'b0, f_lw_wb());
      push(sw, 1'b1, 1'b0, f_fetch(1'b1));
      push(sw, 1'b1, 1'b0, f_decode(1'b0));
      push(sw, 1'b1, 1'b0, f_alu_imm(S_MEM_ADDR));
      push(sw, 1'b0, 1'b0, f_mem_wr(1'b0));
      push(sw, 1'b0, 1'b0, f_mem_wr(1'b0));
      push(sw, 1'b1, 1'b0, f_mem_wr(1'b1));
      push(sw, 1'b1, 1'b0, f_fetch(1'b1));
      while (sb.size() != 0) begin
         it = sb.pop_front();
         apply(it);
         got = observe();
         checks++;
         if (got !== it.exp) begin
            errors++;
            $display("FAIL load_store cycle %0d: got %h expected %h", n, got, it.exp);
         end
         n++;
      end
   endtask

   task automatic test_branch_jump();
      item_t it; ctl_t got; int n = 0;
      logic [31:0] bltz = 32'h0500_0003;
      logic [31:0] j    = 32'h0800_0010;
      logic [31:0] jr   = 32'h03E0_0008;
      do_reset();
      push(bltz, 1'b1, 1'b1, f_fetch(1'b1));
      push(bltz, 1'b1, 1'b1, f_decode(1'b0));
      push(bltz, 1'b1, 1'b1, f_pc(S_BRANCH, 2'b01, 1'b1));
      push(bltz, 1'b1, 1'b0, f_fetch(1'b1));
      push(bltz, 1'b1, 1'b0, f_decode(1'b0));
      push(bltz, 1'b1, 1'b0, f_pc(S_BRANCH, 2'b01, 1'b0));
      push(j,    1'b1, 1'b0, f_fetch(1'b1));
      push(j,    1'b1, 1'b0, f_decode(1'b0));
      push(j,    1'b1, 1'b0, f_pc(S_JUMP, 2'b10, 1'b1));
      push(jr,   1'b1, 1'b0, f_fetch(1'b1));
      push(jr,   1'b1, 1'b0, f_decode(1'b0));
      push(jr,   1'b1, 1'b0, f_pc(S_JR_S, 2'b11, 1'b1));
      push(jr,   1'b1, 1'b0, f_fetch(1'b1));
      while (sb.size() != 0) begin
         it = sb.pop_front();
         apply(it);
         got = observe();
         checks++;
         if (got !== it.exp) begin
            errors++;
            $display("FAIL branch_jump cycle %0d: got %h expected %h", n, got, it.exp);
         end
         n++;
      end
   endtask

   task automatic test_illegal_nop();
      item_t it; ctl_t got; int n = 0;
      logic [31:0] nop = 32'h0000_0000;
      logic [31:0] bad = 32'hE800_0000;
      do_reset();
      push(nop, 1'b1, 1'b0, f_fetch(1'b1));
      push(nop, 1'b1, 1'b0, f_decode(1'b1));
      push(bad, 1'b1, 1'b0, f_fetch(1'b1));
      push(bad, 1'b1, 1'b0, f_decode(1'b1));
      exp_ill = 1'b1;
      push(nop, 1'b1, 1'b0, f_fetch(1'b1));
      push(nop, 1'b1, 1'b0, f_decode(1'b1));
      push(nop, 1'b1, 1'b0, f_fetch(1'b1));
      while (sb.size() != 0) begin
         it = sb.pop_front();
         apply(it);
         got = observe();
         checks++;
         if (got !== it.exp) begin
            errors++;
            $display("FAIL illegal_nop cycle %0d: got %h expected %h", n, got, it.exp);
         end
         n++;
      end
   endtask

   task automatic test_watchdog();
      item_t it; ctl_t got; int n = 0;
      logic [31:0] addi = 32'h2008_0005;
      // Ready on the fourth cycle beats the timeout.
      do_reset();
      for (int i = 0; i < 3; i++) push(addi, 1'b0, 1'b0, f_fetch(1'b0));
      push(addi, 1'b1, 1'b0, f_fetch(1'b1));
      push(addi, 1'b1, 1'b0, f_decode(1'b0));
      push(addi, 1'b1, 1'b0, f_alu_imm(S_EXEC_I));
      while (sb.size() != 0) begin
         it = sb.pop_front();
         apply(it);
         got = observe();
         checks++;
         if (got !== it.exp) begin
            errors++;
            $display("FAIL watchdog_ready cycle %0d: got %h expected %h", n, got, it.exp);
         end
         n++;
      end
      // Four not-ready cycles trap; FAULT then ignores mem_ready.
      do_reset();
      n = 0;
      for (int i = 0; i < 4; i++) push(addi, 1'b0, 1'b0, f_fetch(1'b0));
      push(addi, 1'b1, 1'b0, f_fault());
      push(addi, 1'b1, 1'b0, f_fault());
      push(addi, 1'b0, 1'b0, f_fault());
      while (sb.size() != 0) begin
         it = sb.pop_front();
         apply(it);
         got = observe();
         checks++;
         if (got !== it.exp) begin
            errors++;
            $display("FAIL watchdog_fault cycle %0d: got %h expected %h", n, got, it.exp);
         end
         n++;
      end
   endtask

   task automatic test_reset_mid_write();
      item_t it; ctl_t got; int n = 0;
      logic [31:0] sw = 32'hAC08_0004;
      do_reset();
      push(sw, 1'b1, 1'b0, f_fetch(1'b1));
      push(sw, 1'b1, 1'b0, f_decode(1'b0));
      push(sw, 1'b1, 1'b0, f_alu_imm(S_MEM_ADDR));
      push(sw, 1'b0, 1'b0, f_mem_wr(1'b0));
      push(sw, 1'b0, 1'b0, f_mem_wr(1'b0));
      while (sb.size() != 0) begin
         it = sb.pop_front();
         apply(it);
         got = observe();
         checks++;
         if (got !== it.exp) begin
            errors++;
            $display("FAIL reset_mid_write cycle %0d: got %h expected %h", n, got, it.exp);
         end
         n++;
      end
      // Asynchronous reset between clock edges must drop mem_write at once.
      #2;
      reset = 1'b1;
      #1;
      got = observe();
      checks++;
      if (got !== base(S_RST)) begin
         errors++;
         $display("FAIL reset_async_drop: got %h expected %h", got, base(S_RST));
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      got = observe();
      checks++;
      if (got !== base(S_RST)) begin
         errors++;
         $display("FAIL reset_restart_rst: got %h expected %h", got, base(S_RST));
      end
      push(sw, 1'b1, 1'b0, f_fetch(1'b1));
      it = sb.pop_front();
      apply(it);
      got = observe();
      checks++;
      if (got !== it.exp) begin
         errors++;
         $display("FAIL reset_restart_fetch: got %h expected %h", got, it.exp);
      end
   endtask

   initial begin
      reset           = 1'b1;
      bus.instruction = 32'h0;
      bus.mem_ready   = 1'b0;
      bus.rs_neg      = 1'b0;
      test_reset();
      test_addi();
      test_back_to_back_rtype();
      test_load_store();
      test_branch_jump();
      test_illegal_nop();
      test_watchdog();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL sim_timeout: bench did not complete within 50000 time units");
      $fatal(1, "simulation time limit exceeded");
   end

endmodule
